// File: rtl/uart_pkg.sv
// Shared UART constants and the baud-divisor helper used by uart_baud_gen and its sub-module.
package uart_pkg;

    localparam int UART_OVERSAMPLE  = 16;
    localparam int UART_DIV_W       = 11;
    localparam int UART_FRAC_W      = 4;
    localparam int UART_DEFAULT_DIV = 163;

    // Integer clk cycles per oversample tick for a given system clock and baud rate.
    function automatic int uart_baud_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_bit_phase.sv
// Oversample phase counter with bit-centre / bit-end decode and the 50% duty bit clock.
module uart_bit_phase
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic os_tick_i,
    input  logic clear_i,
    output logic mid_tick_o,
    output logic bit_tick_o,
    output logic bclk_o
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            bclk_q, bclk_d;

    assign mid_tick_o = os_tick_i & (phase_q == PH_MID);
    assign bit_tick_o = os_tick_i & (phase_q == PH_LAST);
    assign bclk_o     = bclk_q;

    // bclk toggles on both the centre and end strobes, giving one full period per bit.
    always_comb begin
        phase_d = phase_q;
        bclk_d  = bclk_q;
        if (clear_i) begin
            phase_d = '0;
            bclk_d  = 1'b0;
        end else if (os_tick_i) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            if (mid_tick_o | bit_tick_o) begin
                bclk_d = ~bclk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            bclk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            bclk_q  <= bclk_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Runtime-loadable UART baud generator: oversample, bit-centre and bit-end strobes plus bclk.
// Define UART_BAUD_FRAC_EN to build the fractional divisor accumulator.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W       = UART_DIV_W,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int FRAC_W      = UART_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              bclk
);

    localparam logic [DIV_W:0] ONE_X = (DIV_W + 1)'(1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] eff;
    logic [DIV_W:0]   tc;
    logic             carry;
    logic             clear;

    assign clear = div_load | resync;
    assign eff   = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
    // One extra bit so eff-1+carry cannot wrap at the top of the divisor range.
    assign tc      = {1'b0, eff} - ONE_X + {{DIV_W{1'b0}}, carry};
    assign os_tick = en & ~clear & ({1'b0, cnt_q} == tc);

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
    assign carry   = acc_sum[FRAC_W];

    always_comb begin
        frac_d = frac_q;
        acc_d  = acc_q;
        if (div_load) begin
            frac_d = div_frac;
            acc_d  = '0;
        end else if (resync) begin
            acc_d = '0;
        end else if (os_tick) begin
            acc_d = acc_sum[FRAC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_q <= '0;
            acc_q  <= '0;
        end else begin
            frac_q <= frac_d;
            acc_q  <= acc_d;
        end
    end
`else
    logic unused_div_frac;
    assign unused_div_frac = ^div_frac;
    assign carry           = 1'b0;
`endif

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (div_load) begin
            div_d = div;
            cnt_d = '0;
        end else if (resync || os_tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_W'(DEFAULT_DIV);
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    uart_bit_phase #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_phase (
        .clk        (clk),
        .rst_n      (rst_n),
        .os_tick_i  (os_tick),
        .clear_i    (clear),
        .mid_tick_o (mid_tick),
        .bit_tick_o (bit_tick),
        .bclk_o     (bclk)
    );

endmodule
